uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//   Serialises one parallel word per frame onto a UART line:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
//   then one or two stop bits (1). All bit boundaries are paced by `tick`.
//   A new word offered during the final stop bit's tick is chained directly
//   into the next start bit, with no idle bit between the frames.
//
// Parameters
//   DATA_WIDTH  data bits per frame, 5..9
//
// Ports
//   clk         rising-edge clock
//   rstn        synchronous active-low reset
//   p_data      word to transmit (latched on acceptance)
//   data_valid  transmit request
//   data_ready  a word is accepted on this cycle's edge if data_valid is high
//   par_en      insert a parity bit (latched on acceptance)
//   par_type    0 = even parity, 1 = odd parity (latched on acceptance)
//   stop2       0 = one stop bit, 1 = two stop bits (latched on acceptance)
//   tick        one-cycle bit-rate strobe
//   tx_out      registered serial line, idles high
//   busy        registered, high whenever the block is not idle
//   frame_done  registered one-cycle pulse as the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  input  logic                  tick,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_d, busy_d, done_d;
  logic                  final_stop;
  logic                  accept;
  logic                  parity_bit;
  logic [CNT_W-1:0]      cnt_inc;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the latched frame settings are datapath registers, but they are
      // cleared here too so a reset leaves no trace of an aborted frame.
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;
      tx_out     <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, next-output and handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // The last stop bit is STOP2 when two stop bits were requested.
    final_stop = (state_q == STOP2) || ((state_q == STOP1) && !stop2_q);
    data_ready = (state_q == IDLE) || (final_stop && tick);
    accept     = data_valid && data_ready;
    parity_bit = (^data_q) ^ par_type_q;
    cnt_inc    = cnt_q + CNT_W'(1);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;
    tx_d       = tx_out;
    done_d     = 1'b0;

    if (accept) begin
      data_d     = p_data;
      par_en_d   = par_en;
      par_type_d = par_type;
      stop2_d    = stop2;
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = PEND;
      end
      PEND: begin
        // Wait for a bit boundary so the start bit is a full tick period.
        if (tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_bit;
            end else begin
              state_d = STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            tx_d  = data_q[cnt_inc];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
      end
      STOP1, STOP2: begin
        if (tick) begin
          if ((state_q == STOP1) && stop2_q) begin
            state_d = STOP2;
            tx_d    = 1'b1;
          end else begin
            done_d = 1'b1;
            // A word accepted here starts immediately: back-to-back frames.
            if (accept) begin
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//   Self-checking bench for uart_tx_framer. Two instances are exercised:
//   DATA_WIDTH=8 and DATA_WIDTH=5. The reference model builds each frame as a
//   list of line bits and predicts the line cycle by cycle purely from the
//   number of ticks seen since acceptance.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  logic       clk;
  logic       rstn;
  logic       tick;
  logic       par_en;
  logic       par_type;
  logic       stop2;

  logic [7:0] p_data8;
  logic       valid8;
  logic       ready8, tx8, busy8, done8;

  logic [4:0] p_data5;
  logic       valid5;
  logic       ready5, tx5, busy5, done5;

  int vectors     = 0;
  int miscompares = 0;
  int period      = 1;
  int phase       = 0;
  bit sel5        = 1'b0;

  uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
    .clk        (clk),
    .rstn       (rstn),
    .p_data     (p_data8),
    .data_valid (valid8),
    .data_ready (ready8),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
    .tick       (tick),
    .tx_out     (tx8),
    .busy       (busy8),
    .frame_done (done8)
  );

  uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
    .clk        (clk),
    .rstn       (rstn),
    .p_data     (p_data5),
    .data_valid (valid5),
    .data_ready (ready5),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
    .tick       (tick),
    .tx_out     (tx5),
    .busy       (busy5),
    .frame_done (done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_period(input int p);
    period = p;
    phase  = $urandom % p;
  endtask

  // Drives tick for the coming edge; one pulse every `period` cycles.
  task automatic drive_tick();
    tick  = (phase == 0);
    phase = (phase + 1) % period;
  endtask

  task automatic set_word(input logic [8:0] d, input logic v);
    if (sel5) begin
      p_data5 = d[4:0];
      valid5  = v;
    end else begin
      p_data8 = d[7:0];
      valid8  = v;
    end
  endtask

  // Sends one frame and checks every cycle of it.
  //   started  : the start bit is already on the line (chained frame)
  //   chain    : hold data_valid high with nd so the next frame chains
  //   abort_at : return once this many ticks were seen (0 = never)
  task automatic run_frame(input logic [8:0] d, input logic pe, input logic pt,
                           input logic s2, input bit started, input bit chain,
                           input logic [8:0] nd, input int abort_at);
    logic q[$];
    logic p;
    logic exp_ready;
    logic obs_tx, obs_busy, obs_done, obs_ready;
    int   w, n, t, c1, cd;
    bit   got_end, aborted;

    w = sel5 ? 5 : 8;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) q.push_back(d[i]);
    if (pe) begin
      p = pt;
      for (int i = 0; i < w; i++) p = p ^ d[i];
      q.push_back(p);
    end
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    n = q.size();

    if (!started) begin
      set_word(d, 1'b1);
      par_en   = pe;
      par_type = pt;
      stop2    = s2;
      t        = 0;
    end else begin
      t = 1;
    end
    c1      = -1;
    cd      = -1;
    got_end = 1'b0;
    aborted = 1'b0;

    for (int c = 0; c < 2000 && !got_end && !aborted; c++) begin
      drive_tick();
      if (c > 0) begin
        if (chain) begin
          set_word(nd, 1'b1);
        end else begin
          // Noise: latched settings must not follow these inputs.
          set_word(9'($urandom), 1'($urandom) && !(t == n && tick));
          par_en   = 1'($urandom);
          par_type = 1'($urandom);
          stop2    = 1'($urandom);
        end
      end
      exp_ready = (!started && c == 0) ? 1'b1 : (t == n && tick);
      #1;
      obs_ready = sel5 ? ready5 : ready8;
      check("data_ready", obs_ready, exp_ready);

      @(posedge clk);
      #1;
      // The acceptance edge moves IDLE to PEND whatever tick is.
      if (tick && !(c == 0 && !started)) t++;
      if (t == 1 && c1 < 0) c1 = c;
      obs_tx   = sel5 ? tx5   : tx8;
      obs_busy = sel5 ? busy5 : busy8;
      obs_done = sel5 ? done5 : done8;
      if (t == n + 1) begin
        check("tx_end",   obs_tx,   chain ? 1'b0 : 1'b1);
        check("busy_end", obs_busy, chain ? 1'b1 : 1'b0);
        check("done_end", obs_done, 1'b1);
        got_end = 1'b1;
        cd      = c;
      end else begin
        check("tx_bit",  obs_tx,   (t == 0) ? 1'b1 : q[t-1]);
        check("busy",    obs_busy, 1'b1);
        check("no_done", obs_done, 1'b0);
        if (abort_at != 0 && t == abort_at) aborted = 1'b1;
      end
    end

    if (!aborted) begin
      check("frame_end", got_end, 1'b1);
      if (!started && got_end) check("frame_len", cd - c1, n * period);
    end

    if (!chain && !aborted) begin
      drive_tick();
      set_word(9'($urandom), 1'b0);
      #1;
      check("ready_idle", sel5 ? ready5 : ready8, 1'b1);
      @(posedge clk);
      #1;
      check("done_pulse", sel5 ? done5 : done8, 1'b0);
      check("busy_idle",  sel5 ? busy5 : busy8, 1'b0);
      check("tx_idle",    sel5 ? tx5   : tx8,   1'b1);
    end
  endtask

  initial begin
    logic [8:0] d1, d2;
    logic       pe, pt, s2;

    rstn     = 1'b0;
    tick     = 1'b0;
    par_en   = 1'b0;
    par_type = 1'b0;
    stop2    = 1'b0;
    p_data8  = '0;
    p_data5  = '0;
    valid8   = 1'b0;
    valid5   = 1'b0;
    set_period(1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx8",    tx8,    1'b1);
    check("rst_busy8",  busy8,  1'b0);
    check("rst_done8",  done8,  1'b0);
    check("rst_ready8", ready8, 1'b1);
    check("rst_tx5",    tx5,    1'b1);
    check("rst_busy5",  busy5,  1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5, no parity, one stop bit, tick always high
    run_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 0);
    // Even and odd parity
    run_frame(9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 0);
    run_frame(9'h0A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 0);

    // Slow tick, two stop bits
    set_period(16);
    run_frame(9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 0);

    // Back-to-back 0x55 then 0x0F
    set_period(1);
    run_frame(9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h00F, 0);
    run_frame(9'h00F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 0);

    // Reset while data bit 3 is on the line (start + bits 0..3 = 5 ticks)
    run_frame(9'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 5);
    drive_tick();
    rstn   = 1'b0;
    valid8 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx",   tx8,   1'b1);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    rstn   = 1'b1;
    valid8 = 1'b0;
    #1;
    check("ready_after_rst", ready8, 1'b1);
    drive_tick();
    @(posedge clk);
    #1;
    check("abort_no_done", done8, 1'b0);
    run_frame(9'h03C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 0);

    // Five-bit instance: 0x13 with odd parity
    sel5 = 1'b1;
    run_frame(9'h013, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 0);
    sel5 = 1'b0;

    // Randomised frames on both widths, some chained
    for (int k = 0; k < 24; k++) begin
      sel5 = 1'($urandom);
      set_period($urandom_range(1, 5));
      d1 = 9'($urandom);
      d2 = 9'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      s2 = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        run_frame(d1, pe, pt, s2, 1'b0, 1'b1, d2, 0);
        run_frame(d2, pe, pt, s2, 1'b1, 1'b0, 9'h0, 0);
      end else begin
        run_frame(d1, pe, pt, s2, 1'b0, 1'b0, 9'h0, 0);
      end
    end
    sel5 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
